ddr4_lane_dly_trainer: RTL and testbench
========================================

DDR4_LANE_DLY_TRAINER -- requirements
Module: ddr4_lane_dly_trainer

Interface
REQ-001 SHALL have parameter MAX_TAPS, default 128: number of delay-line taps swept (2..256).
REQ-002 SHALL have parameter READ_WAIT, default 16: cycles from read request to burst-detect sample (1..255).
REQ-003 SHALL have parameter MIN_WINDOW, default 4: minimum consecutive passing taps for a valid window.
REQ-004 SHALL have port FAB_CLK, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port RESET, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port TRAIN_START, input, 1: one-cycle request to begin training.
REQ-007 SHALL have port RX_BURST_DETECT, input, 1: lane reports a DQS burst for the issued read (pass).
REQ-008 SHALL have port RX_DELAY_LINE_OUT_OF_RANGE, input, 1: delay line at its limit.
REQ-009 SHALL have port DELAY_LINE_SEL, output, 1: selects the RX DQS delay line; high while BUSY.
REQ-010 SHALL have port DELAY_LINE_LOAD, output, 1: one-cycle pulse that returns the delay line to tap 0.
REQ-011 SHALL have port DELAY_LINE_DIRECTION, output, 1: 1 = increment, 0 = decrement.
REQ-012 SHALL have port DELAY_LINE_MOVE, output, 1: one-cycle pulse that moves one tap.
REQ-013 SHALL have port HS_IO_CLK_PAUSE, output, 1: pauses the lane high-speed clock around moves.
REQ-014 SHALL have port DDR_READ_REQ, output, 1: one-cycle pulse requesting a training read burst.
REQ-015 SHALL have ports BUSY, TRAIN_DONE, TRAIN_FAIL, outputs, 1 each: status.
REQ-016 SHALL have ports TAP_CENTER and WIN_WIDTH, outputs, 8 each: result tap and window width.

Function
REQ-017 SHALL implement states IDLE, LOAD, REQ, WAIT, SAMPLE, STEP, CENTER, DONE, FAIL.
REQ-018 IDLE: TRAIN_START -> LOAD; TRAIN_START while BUSY is ignored.
REQ-019 LOAD: DELAY_LINE_LOAD high one cycle, tap counter := 0, window registers cleared -> REQ.
REQ-020 REQ: DDR_READ_REQ high one cycle -> WAIT; WAIT counts READ_WAIT cycles -> SAMPLE.
REQ-021 SAMPLE: a pass at tap T sets first := T if no window is open, else last := T.
REQ-022 SAMPLE: a fail with an open window of width (last-first+1) >= MIN_WINDOW closes the sweep -> CENTER; a fail with width < MIN_WINDOW discards the window.
REQ-023 SAMPLE: T = MAX_TAPS-1 or RX_DELAY_LINE_OUT_OF_RANGE ends the sweep -> CENTER if the window is valid, else FAIL; otherwise -> STEP.
REQ-024 STEP: DIRECTION=1 with a MOVE pulse, then one idle gap cycle, T := T+1 -> REQ.
REQ-025 CENTER: center := first + ((last-first) >> 1), floor; issue (T - center) decrement moves, each a MOVE pulse plus one gap cycle -> DONE.
REQ-026 DONE: TAP_CENTER := center, WIN_WIDTH := last-first+1, TRAIN_DONE held high until the next TRAIN_START.
REQ-027 FAIL: TRAIN_FAIL held high, TAP_CENTER = 0, WIN_WIDTH = 0, delay line left at the sweep end tap.
REQ-028 BUSY SHALL be high in every state except IDLE, DONE and FAIL; TRAIN_START from DONE or FAIL -> LOAD and clears both flags.
REQ-029 A window still open at sweep end is valid if width >= MIN_WINDOW.
REQ-030 Tap arithmetic SHALL be 8-bit unsigned and SHALL never wrap.

Reset
REQ-031 RESET high SHALL force IDLE on the next edge, including mid-sweep or mid-move.
REQ-032 RESET high SHALL drive every output to 0, including DELAY_LINE_DIRECTION; no partial move pulse may be emitted.

Configuration
REQ-033 Macro DDR4_TRAIN_CLK_PAUSE_EN defined: HS_IO_CLK_PAUSE high in the cycle before, during and after each MOVE or LOAD pulse; each move gap grows to 2 cycles.
REQ-034 Macro DDR4_TRAIN_CLK_PAUSE_EN undefined: HS_IO_CLK_PAUSE tied 0; gap stays 1 cycle.

Structure
REQ-035 Package ddr4_train_pkg SHALL hold the state enum typedef, TAP_W=8 and the default parameter constants.
REQ-036 One sub-module, ddr4_train_win_track, SHALL hold the first/last/width window registers and the valid-window compare.

Verification
REQ-037 Pass taps 20..39, MAX_TAPS=128: sweep stops at T=40, 11 decrements, TAP_CENTER=29, WIN_WIDTH=20, TRAIN_DONE=1.
REQ-038 Pass taps 5..7 then 50..60, MIN_WINDOW=4: first window discarded, TAP_CENTER=55, WIN_WIDTH=11.
REQ-039 No pass at any tap: 127 MOVE pulses, TRAIN_FAIL=1, TAP_CENTER=0, WIN_WIDTH=0.
REQ-040 OUT_OF_RANGE asserted at T=90 with passes from tap 80: TAP_CENTER=85, no further moves up.
REQ-041 RESET asserted in WAIT at T=33: next cycle all outputs 0 and state IDLE; a new TRAIN_START pulses LOAD.
REQ-042 With DDR4_TRAIN_CLK_PAUSE_EN defined: HS_IO_CLK_PAUSE spans exactly 3 cycles around each MOVE; TRAIN_START while BUSY has no effect.

Source files
------------

// File: rtl/ddr4_train_pkg.sv
// Shared types and constants for the DDR4 lane RX DQS delay trainer.
// Holds the FSM state type, the tap width and the default parameter values.
package ddr4_train_pkg;

    localparam int TAP_W          = 8;
    localparam int DEF_MAX_TAPS   = 128;
    localparam int DEF_READ_WAIT  = 16;
    localparam int DEF_MIN_WINDOW = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_REQ    = 4'd2,
        ST_WAIT   = 4'd3,
        ST_SAMPLE = 4'd4,
        ST_STEP   = 4'd5,
        ST_CENTER = 4'd6,
        ST_DONE   = 4'd7,
        ST_FAIL   = 4'd8
    } train_state_e;

    // Floor midpoint; last >= first always, so no wrap is possible.
    function automatic logic [TAP_W-1:0] tap_center(input logic [TAP_W-1:0] first,
                                                    input logic [TAP_W-1:0] last);
        logic [TAP_W-1:0] span;
        span = last - first;
        return first + (span >> 1);
    endfunction

    function automatic logic [TAP_W-1:0] sat_width(input logic [TAP_W:0] w);
        return (w > 9'd255) ? 8'hFF : w[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/ddr4_train_win_track.sv
// Passing-window tracker: first/last tap registers, window width and the
// minimum-width validity compare, both for the stored window and for a pass at the current tap.
module ddr4_train_win_track
    import ddr4_train_pkg::*;
#(
    parameter int MIN_WINDOW = DEF_MIN_WINDOW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             sample_i,
    input  logic             pass_i,
    input  logic [TAP_W-1:0] tap_i,
    output logic [TAP_W-1:0] first_o,
    output logic [TAP_W-1:0] last_o,
    output logic [TAP_W:0]   width_o,
    output logic             valid_o,
    output logic             pass_valid_o
);

    localparam logic [TAP_W:0] MIN_W = MIN_WINDOW[TAP_W:0];

    logic [TAP_W-1:0] first_q, first_d, last_q, last_d;
    logic             open_q, open_d;
    logic [TAP_W-1:0] cand_first_s;
    logic [TAP_W:0]   cand_width_s;

    // Width and validity of the stored window and of the window a pass would extend.
    always_comb begin
        cand_first_s = open_q ? first_q : tap_i;
        cand_width_s = {1'b0, tap_i} - {1'b0, cand_first_s} + 9'd1;
        width_o      = {1'b0, last_q} - {1'b0, first_q} + 9'd1;
        valid_o      = open_q && (width_o >= MIN_W);
        pass_valid_o = cand_width_s >= MIN_W;
    end

    // Window update on each sampled tap; a fail discards a window that is too narrow.
    always_comb begin
        first_d = first_q;
        last_d  = last_q;
        open_d  = open_q;
        if (clr_i) begin
            first_d = 8'd0;
            last_d  = 8'd0;
            open_d  = 1'b0;
        end else if (sample_i && pass_i) begin
            first_d = cand_first_s;
            last_d  = tap_i;
            open_d  = 1'b1;
        end else if (sample_i && !valid_o) begin
            open_d  = 1'b0;
        end else begin
            open_d  = open_q;
        end
    end

    // Window state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            first_q <= 8'd0;
            last_q  <= 8'd0;
            open_q  <= 1'b0;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
            open_q  <= open_d;
        end
    end

    assign first_o = first_q;
    assign last_o  = last_q;

endmodule

// File: rtl/ddr4_lane_dly_trainer.sv
// DDR4 lane RX DQS delay trainer: sweeps the delay line, finds the passing window, centres on it.
// Optional macro DDR4_TRAIN_CLK_PAUSE_EN pauses the HS IO clock around every MOVE/LOAD pulse.
module ddr4_lane_dly_trainer
    import ddr4_train_pkg::*;
#(
    parameter int MAX_TAPS   = DEF_MAX_TAPS,
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int MIN_WINDOW = DEF_MIN_WINDOW
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       TRAIN_START,
    input  logic       RX_BURST_DETECT,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       HS_IO_CLK_PAUSE,
    output logic       DDR_READ_REQ,
    output logic       BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_FAIL,
    output logic [7:0] TAP_CENTER,
    output logic [7:0] WIN_WIDTH
);

    localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W-1:0] WAIT_LAST = TAP_W'(READ_WAIT - 1);
`ifdef DDR4_TRAIN_CLK_PAUSE_EN
    localparam logic [2:0] PULSE_PH      = 3'd1;
    localparam logic [2:0] MOVE_LAST_PH  = 3'd3;
    localparam logic [2:0] LOAD_LAST_PH  = 3'd2;
    localparam logic [2:0] PAUSE_LAST_PH = 3'd2;
`else
    localparam logic [2:0] PULSE_PH      = 3'd0;
    localparam logic [2:0] MOVE_LAST_PH  = 3'd1;
    localparam logic [2:0] LOAD_LAST_PH  = 3'd0;
`endif

    train_state_e     state_q, state_d;
    logic [2:0]       ph_q, ph_d, mv_ph_s;
    logic [TAP_W-1:0] tap_q, tap_d, wcnt_q, wcnt_d, tap_dec_s, center_s;
    logic [TAP_W-1:0] first_s, last_s;
    logic [TAP_W:0]   width_s;
    logic             win_clr_s, win_smp_s, win_valid_s, pass_valid_s, sweep_end_s;
    logic             mv_act_s, busy_s, move_s, load_s, pause_s;
    logic             sel_q, load_q, dir_q, move_q, pause_q, rreq_q, busy_q, done_q, fail_q;
    logic [7:0]       tap_center_q, win_width_q;

    ddr4_train_win_track #(.MIN_WINDOW(MIN_WINDOW)) u_win (
        .clk_i        (FAB_CLK),
        .rst_i        (RESET),
        .clr_i        (win_clr_s),
        .sample_i     (win_smp_s),
        .pass_i       (RX_BURST_DETECT),
        .tap_i        (tap_q),
        .first_o      (first_s),
        .last_o       (last_s),
        .width_o      (width_s),
        .valid_o      (win_valid_s),
        .pass_valid_o (pass_valid_s)
    );

    assign center_s  = tap_center(first_s, last_s);
    assign tap_dec_s = tap_q - 8'd1;

    // Sweep sequencing; CENTER phase 0 checks for an already-centred line before any move.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        tap_d       = tap_q;
        wcnt_d      = wcnt_q;
        win_clr_s   = 1'b0;
        win_smp_s   = 1'b0;
        sweep_end_s = (tap_q == LAST_TAP) || RX_DELAY_LINE_OUT_OF_RANGE;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (TRAIN_START) begin
                    state_d = ST_LOAD;
                    ph_d    = 3'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                tap_d     = 8'd0;
                win_clr_s = 1'b1;
                if (ph_q == LOAD_LAST_PH) begin
                    state_d = ST_REQ;
                    ph_d    = 3'd0;
                end else begin
                    ph_d = ph_q + 3'd1;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                wcnt_d  = 8'd0;
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                win_smp_s = 1'b1;
                ph_d      = 3'd0;
                if (RX_BURST_DETECT) begin
                    if (sweep_end_s) begin
                        state_d = pass_valid_s ? ST_CENTER : ST_FAIL;
                    end else begin
                        state_d = ST_STEP;
                    end
                end else if (win_valid_s) begin
                    state_d = ST_CENTER;
                end else if (sweep_end_s) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (ph_q == MOVE_LAST_PH) begin
                    tap_d   = tap_q + 8'd1;
                    ph_d    = 3'd0;
                    state_d = ST_REQ;
                end else begin
                    ph_d = ph_q + 3'd1;
                end
            end
            ST_CENTER: begin
                if (ph_q == 3'd0) begin
                    if (tap_q == center_s) begin
                        state_d = ST_DONE;
                    end else begin
                        ph_d = 3'd1;
                    end
                end else if (ph_q == MOVE_LAST_PH + 3'd1) begin
                    tap_d = tap_dec_s;
                    if (tap_dec_s == center_s) begin
                        state_d = ST_DONE;
                        ph_d    = 3'd0;
                    end else begin
                        ph_d = 3'd1;
                    end
                end else begin
                    ph_d = ph_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ph_d    = 3'd0;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        mv_act_s = 1'b0;
        mv_ph_s  = 3'd0;
        if (state_d == ST_STEP) begin
            mv_act_s = 1'b1;
            mv_ph_s  = ph_d;
        end else if ((state_d == ST_CENTER) && (ph_d != 3'd0)) begin
            mv_act_s = 1'b1;
            mv_ph_s  = ph_d - 3'd1;
        end else begin
            mv_act_s = 1'b0;
        end
        busy_s = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL));
        move_s = mv_act_s && (mv_ph_s == PULSE_PH);
        load_s = (state_d == ST_LOAD) && (ph_d == PULSE_PH);
`ifdef DDR4_TRAIN_CLK_PAUSE_EN
        pause_s = (mv_act_s && (mv_ph_s <= PAUSE_LAST_PH)) || (state_d == ST_LOAD);
`else
        pause_s = 1'b0;
`endif
    end

    // State, counters and registered outputs; reset clears everything including DIRECTION.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            ph_q         <= 3'd0;
            tap_q        <= 8'd0;
            wcnt_q       <= 8'd0;
            sel_q        <= 1'b0;
            load_q       <= 1'b0;
            dir_q        <= 1'b0;
            move_q       <= 1'b0;
            pause_q      <= 1'b0;
            rreq_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            tap_center_q <= 8'd0;
            win_width_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            tap_q        <= tap_d;
            wcnt_q       <= wcnt_d;
            sel_q        <= busy_s;
            load_q       <= load_s;
            dir_q        <= (state_d == ST_STEP);
            move_q       <= move_s;
            pause_q      <= pause_s;
            rreq_q       <= (state_d == ST_REQ);
            busy_q       <= busy_s;
            done_q       <= (state_d == ST_DONE);
            fail_q       <= (state_d == ST_FAIL);
            tap_center_q <= (state_d == ST_DONE) ? center_s : 8'd0;
            win_width_q  <= (state_d == ST_DONE) ? sat_width(width_s) : 8'd0;
        end
    end

    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign HS_IO_CLK_PAUSE      = pause_q;
    assign DDR_READ_REQ         = rreq_q;
    assign BUSY                 = busy_q;
    assign TRAIN_DONE           = done_q;
    assign TRAIN_FAIL           = fail_q;
    assign TAP_CENTER           = tap_center_q;
    assign WIN_WIDTH            = win_width_q;

endmodule

// File: tb/tb_ddr4_lane_dly_trainer.sv
// Scoreboard bench for ddr4_lane_dly_trainer: a lane model answers reads from its own tap position,
// each run pushes hand-computed results, and a monitor checks them when DONE/FAIL rises.
module tb_ddr4_lane_dly_trainer;

    logic       FAB_CLK = 1'b0;
    logic       RESET, TRAIN_START, RX_BURST_DETECT, RX_DELAY_LINE_OUT_OF_RANGE;
    logic       DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
    logic       HS_IO_CLK_PAUSE, DDR_READ_REQ, BUSY, TRAIN_DONE, TRAIN_FAIL;
    logic [7:0] TAP_CENTER, WIN_WIDTH;

    always #5 FAB_CLK = ~FAB_CLK;

    ddr4_lane_dly_trainer dut (
        .FAB_CLK                    (FAB_CLK),
        .RESET                      (RESET),
        .TRAIN_START                (TRAIN_START),
        .RX_BURST_DETECT            (RX_BURST_DETECT),
        .RX_DELAY_LINE_OUT_OF_RANGE (RX_DELAY_LINE_OUT_OF_RANGE),
        .DELAY_LINE_SEL             (DELAY_LINE_SEL),
        .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
        .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
        .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
        .DDR_READ_REQ               (DDR_READ_REQ),
        .BUSY                       (BUSY),
        .TRAIN_DONE                 (TRAIN_DONE),
        .TRAIN_FAIL                 (TRAIN_FAIL),
        .TAP_CENTER                 (TAP_CENTER),
        .WIN_WIDTH                  (WIN_WIDTH)
    );

    typedef struct {
        logic fail;
        int   center;
        int   width;
        int   ups;
        int   dns;
        int   pos;
        int   loads;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0, n_fail = 0;
    int   pos = 0, ups = 0, dns = 0, loads = 0, proto_bad = 0, pause_run = 0;
    logic move_prev = 1'b0, fin_prev = 1'b0;
    int   lo0 = 1000, hi0 = -1, lo1 = 1000, hi1 = -1, oor_tap = 1000;

    // Lane model: passing taps and the out-of-range limit as seen at the current position.
    always_comb begin
        RX_BURST_DETECT = ((pos >= lo0) && (pos <= hi0)) || ((pos >= lo1) && (pos <= hi1));
        RX_DELAY_LINE_OUT_OF_RANGE = (pos >= oor_tap);
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return {DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
                HS_IO_CLK_PAUSE, DDR_READ_REQ, BUSY, TRAIN_DONE, TRAIN_FAIL, TAP_CENTER, WIN_WIDTH};
    endfunction

    // Delay-line position tracking plus pulse-shape checks.
    always @(negedge FAB_CLK) begin
        if (DELAY_LINE_LOAD) begin
            pos = 0; ups = 0; dns = 0; loads++;
        end else if (DELAY_LINE_MOVE) begin
            if (DELAY_LINE_DIRECTION) begin pos++; ups++; end
            else begin pos--; dns++; end
        end
`ifdef DDR4_TRAIN_CLK_PAUSE_EN
        if (HS_IO_CLK_PAUSE) pause_run++;
        else begin
            if (pause_run != 0 && pause_run != 3) proto_bad++;
            pause_run = 0;
        end
        if (DELAY_LINE_MOVE && !HS_IO_CLK_PAUSE) proto_bad++;
`else
        if (HS_IO_CLK_PAUSE) proto_bad++;
`endif
        if (DELAY_LINE_MOVE && move_prev) proto_bad++;
        move_prev = DELAY_LINE_MOVE;
    end

    // Monitor: compares each completed training against the oldest expectation.
    always @(negedge FAB_CLK) begin
        exp_t e;
        logic fin;
        fin = TRAIN_DONE | TRAIN_FAIL;
        if (fin && !fin_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("fail_flag", int'(TRAIN_FAIL), int'(e.fail));
                check("done_flag", int'(TRAIN_DONE), int'(!e.fail));
                check("tap_center", int'(TAP_CENTER), e.center);
                check("win_width", int'(WIN_WIDTH), e.width);
                check("moves_up", ups, e.ups);
                check("moves_down", dns, e.dns);
                check("final_tap", pos, e.pos);
                check("load_count", loads, e.loads);
                check("busy_at_end", int'(BUSY), 0);
                check("pulse_shape", proto_bad, 0);
            end
        end
        fin_prev = fin;
    end

    task automatic tick();
        @(negedge FAB_CLK);
    endtask

    task automatic wait_fin();
        int k;
        for (k = 0; k < 20000; k++) begin
            if (TRAIN_DONE || TRAIN_FAIL) break;
            tick();
        end
        check("finish_in_time", int'(k < 20000), 1);
    endtask

    task automatic run_case(input int l0, input int h0, input int l1, input int h1, input int oor,
                            input logic f, input int c, input int w, input int u, input int d,
                            input int p, input int ignore_at);
        exp_t e;
        lo0 = l0; hi0 = h0; lo1 = l1; hi1 = h1; oor_tap = oor;
        e.fail = f; e.center = c; e.width = w; e.ups = u; e.dns = d; e.pos = p;
        e.loads = loads + 1;
        sb_q.push_back(e);
        TRAIN_START = 1'b1;
        tick();
        TRAIN_START = 1'b0;
        check("flags_cleared", int'(TRAIN_DONE | TRAIN_FAIL), 0);
        check("sel_while_busy", int'(DELAY_LINE_SEL & BUSY), 1);
        if (ignore_at > 0) begin
            repeat (ignore_at) tick();
            TRAIN_START = 1'b1;
            tick();
            TRAIN_START = 1'b0;
        end
        wait_fin();
        repeat (3) tick();
    endtask

    initial begin
        int k;
        RESET = 1'b1;
        TRAIN_START = 1'b0;
        repeat (3) tick();
        check("reset_outputs", outs(), 0);
        RESET = 1'b0;
        tick();
        check("idle_not_busy", int'(BUSY), 0);

        // Window 20..39 with a TRAIN_START issued mid-sweep that must be ignored.
        run_case(20, 39, 1000, -1, 1000, 1'b0, 29, 20, 40, 11, 29, 100);
        repeat (20) tick();
        check("done_held", int'(TRAIN_DONE), 1);
        // Narrow window discarded, then 50..60.
        run_case(5, 7, 50, 60, 1000, 1'b0, 55, 11, 61, 6, 55, 0);
        // No passing tap anywhere.
        run_case(1000, -1, 1000, -1, 1000, 1'b1, 0, 0, 127, 0, 127, 0);
        repeat (10) tick();
        check("fail_held", int'(TRAIN_FAIL), 1);
        // Out-of-range at tap 90 with passes from 80.
        run_case(80, 300, 1000, -1, 90, 1'b0, 85, 11, 90, 5, 85, 0);
        // Window still open at the last tap.
        run_case(120, 300, 1000, -1, 1000, 1'b0, 123, 8, 127, 4, 123, 0);
        // Open window at the last tap but narrower than the minimum.
        run_case(125, 300, 1000, -1, 1000, 1'b1, 0, 0, 127, 0, 127, 0);
        // Window exactly the minimum width.
        run_case(10, 13, 1000, -1, 1000, 1'b0, 11, 4, 14, 3, 11, 0);

        // Reset during WAIT at tap 33.
        lo0 = 1000; hi0 = -1; lo1 = 1000; hi1 = -1; oor_tap = 1000;
        TRAIN_START = 1'b1;
        tick();
        TRAIN_START = 1'b0;
        for (k = 0; k < 5000; k++) begin
            if (DDR_READ_REQ && pos == 33) break;
            tick();
        end
        check("reach_tap33", int'(k < 5000), 1);
        tick();
        RESET = 1'b1;
        tick();
        check("reset_mid_sweep", outs(), 0);
        RESET = 1'b0;
        run_case(20, 39, 1000, -1, 1000, 1'b0, 29, 20, 40, 11, 29, 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
